// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response bus bundle between the two requesters, the arbiter and backing memory
//
// Purpose: groups every non-clock, non-reset signal of mem_arbiter.
// Signal names carry the arbiter's point of view (_i = into the arbiter,
// _o = out of the arbiter).
//
// Ports (signals):
//   if_req_i    1   fetch request, level, held until if_ack_o
//   if_addr_i   32  fetch byte address
//   if_data_o   32  fetched instruction, valid with if_ack_o
//   if_ack_o    1   one-cycle fetch completion pulse
//   d_req_i     1   data request, level, held until d_ack_o
//   d_we_i      1   1 = store, 0 = load
//   d_addr_i    32  data byte address
//   d_wdata_i   32  store data
//   d_rdata_o   32  load data, valid with d_ack_o
//   d_ack_o     1   one-cycle data completion pulse
//   mem_enable_o 1  backing-memory request, level
//   mem_write_o 1   backing-memory write strobe
//   mem_addr_o  32  backing-memory address
//   mem_data_o  32  backing-memory write data
//   mem_data_i  32  backing-memory read data, valid with mem_ack_i
//   mem_ack_i   1   backing-memory completion, one cycle
//   stall_o     1   pipeline stall
//
// Modports: slave = the arbiter, master = the environment (CPU + memory).
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        mem_enable_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;
  logic        stall_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_data_i, mem_ack_i,
    output if_data_o, if_ack_o, d_rdata_o, d_ack_o,
           mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, stall_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_data_i, mem_ack_i,
    input  if_data_o, if_ack_o, d_rdata_o, d_ack_o,
           mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single-outstanding backing memory
//
// Purpose: shares one backing memory between an instruction-fetch port and
// a data port. Data normally has priority; a 4-bit starve counter forces a
// fetch grant after STARVE_MAX data grants taken while fetch was waiting.
// Exactly one memory transaction is outstanding at a time.
//
// Ports:
//   clk_i  in   single clock, all state on rising edge
//   rst_i  in   asynchronous, active-high reset
//   bus    slave modport of mem_arbiter_if (fetch port, data port,
//               backing-memory port, stall_o)
//
// Parameters:
//   STARVE_MAX  data grants allowed while fetch waits (1..15)
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q;
  state_t      next_state;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        mem_write_q;
  logic [31:0] if_data_q;
  logic [31:0] d_rdata_q;
  logic        if_ack_q;
  logic        d_ack_q;
  logic [3:0]  starve_q;

  logic        if_elig;
  logic        d_elig;
  logic        starve_full;
  logic        grant_i;
  logic        grant_d;

  // Arbitration. A requester whose ack is pulsing this cycle still has its
  // req high (it drops it only after seeing the ack), so it is masked out
  // to avoid granting the same request twice.
  always_comb begin
    if_elig     = bus.if_req_i & ~if_ack_q;
    d_elig      = bus.d_req_i & ~d_ack_q;
    starve_full = (starve_q == STARVE_LIM);
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    if (state_q == IDLE) begin
      grant_i = if_elig & (~d_elig | starve_full);
      grant_d = d_elig & ~(if_elig & starve_full);
    end
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          next_state = BUSY_D;
        end else if (grant_i) begin
          next_state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic. mem_enable_o decodes straight from the state register so
  // an asynchronous reset drops it immediately.
  always_comb begin
    bus.mem_enable_o = (state_q == BUSY_I) || (state_q == BUSY_D);
    bus.stall_o      = (bus.if_req_i & ~if_ack_q) | (bus.d_req_i & ~d_ack_q);
  end

  // Datapath: memory command registers, read registers, ack pulses and the
  // starve counter. The command registers load only on a grant, so
  // requester changes during BUSY never reach the memory port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      starve_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;

      if (grant_d) begin
        mem_addr_q  <= bus.d_addr_i;
        mem_data_q  <= bus.d_wdata_i;
        mem_write_q <= bus.d_we_i;
      end else if (grant_i) begin
        mem_addr_q  <= bus.if_addr_i;
        mem_data_q  <= '0;
        mem_write_q <= 1'b0;
      end

      // Completions. mem_ack_i outside BUSY (e.g. a straggler from an
      // access aborted by reset) falls through both branches.
      if (state_q == BUSY_I && bus.mem_ack_i) begin
        if_data_q <= bus.mem_data_i;
        if_ack_q  <= 1'b1;
      end
      if (state_q == BUSY_D && bus.mem_ack_i) begin
        if (!mem_write_q) begin
          d_rdata_q <= bus.mem_data_i;
        end
        d_ack_q <= 1'b1;
      end

      if (grant_i) begin
        starve_q <= '0;
      end else if (grant_d && bus.if_req_i && (starve_q < STARVE_LIM)) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.d_ack_o     = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Backing memory: acks lat cycles after mem_enable_o rises (lat = 0 ties
  // the ack to the enable); force_ack injects a stray ack.
  int          lat       = 0;
  logic        force_ack = 1'b0;
  int          wait_cnt  = 0;
  logic [31:0] mem_rdata = '0;

  assign bus.mem_ack_i  = force_ack | (bus.mem_enable_o & (wait_cnt >= lat));
  assign bus.mem_data_i = mem_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!bus.mem_enable_o || bus.mem_ack_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // Grant log (address at each mem_enable_o rise) and ack pulse-width watch.
  logic [31:0] grant_q[$];
  logic        en_prev     = 1'b0;
  logic        if_ack_prev = 1'b0;
  logic        d_ack_prev  = 1'b0;
  int          ack_run_err = 0;

  always @(negedge clk) begin
    if (bus.mem_enable_o && !en_prev) grant_q.push_back(bus.mem_addr_o);
    if ((bus.if_ack_o && if_ack_prev) || (bus.d_ack_o && d_ack_prev))
      ack_run_err <= ack_run_err + 1;
    en_prev     <= bus.mem_enable_o;
    if_ack_prev <= bus.if_ack_o;
    d_ack_prev  <= bus.d_ack_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input bit data_port, input int budget, output int cycles);
    logic ack;
    cycles = 0;
    ack = data_port ? bus.d_ack_o : bus.if_ack_o;
    while (ack !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
      ack = data_port ? bus.d_ack_o : bus.if_ack_o;
    end
    check(data_port ? "d_ack_seen" : "if_ack_seen", {31'd0, ack}, 32'd1);
  endtask

  bit          req_tab[4]   = '{1, 1, 1, 0};
  bit          en_tab[4]    = '{0, 1, 0, 0};
  bit          ack_tab[4]   = '{0, 0, 1, 0};
  bit          stall_tab[4] = '{1, 1, 0, 0};
  logic [31:0] starve_exp[8] = '{32'h200, 32'h200, 32'h200, 32'h40,
                                 32'h200, 32'h200, 32'h200, 32'h40};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.if_req_i  = 1'b0;
    bus.if_addr_i = '0;
    bus.d_req_i   = 1'b0;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = '0;
    bus.d_wdata_i = '0;

    // Reset state
    step(); step();
    check("rst_enable", {31'd0, bus.mem_enable_o}, 32'd0);
    check("rst_addr",   bus.mem_addr_o, 32'd0);
    check("rst_wdata",  bus.mem_data_o, 32'd0);
    check("rst_write",  {31'd0, bus.mem_write_o}, 32'd0);
    check("rst_if_ack", {31'd0, bus.if_ack_o}, 32'd0);
    check("rst_d_ack",  {31'd0, bus.d_ack_o}, 32'd0);
    check("rst_if_data", bus.if_data_o, 32'd0);
    check("rst_d_rdata", bus.d_rdata_o, 32'd0);
    check("rst_stall",  {31'd0, bus.stall_o}, 32'd0);

    // Fetch only; request raised while still in reset, so no grant yet
    lat = 3;
    mem_rdata = 32'h00A00093;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    step();
    check("rst_hold_enable", {31'd0, bus.mem_enable_o}, 32'd0);
    rst = 1'b0;
    step();
    check("f_enable", {31'd0, bus.mem_enable_o}, 32'd1);
    check("f_addr",   bus.mem_addr_o, 32'h10);
    check("f_write",  {31'd0, bus.mem_write_o}, 32'd0);
    check("f_stall_busy", {31'd0, bus.stall_o}, 32'd1);
    wait_ack(1'b0, 12, cyc);
    check("f_latency", cyc, 32'd4);
    check("f_data",    bus.if_data_o, 32'h00A00093);
    check("f_ack_stall", {31'd0, bus.stall_o}, 32'd0);
    bus.if_req_i = 1'b0;
    step();
    check("f_ack_single", {31'd0, bus.if_ack_o}, 32'd0);
    check("f_stall_after", {31'd0, bus.stall_o}, 32'd0);
    check("f_data_hold", bus.if_data_o, 32'h00A00093);
    check("f_no_regrant", {31'd0, bus.mem_enable_o}, 32'd0);

    // Simultaneous fetch + load: data first, fetch granted in the ack cycle
    lat = 1;
    mem_rdata = 32'h11112222;
    grant_q.delete();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h20;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 32'h100;
    step();
    check("sim_first_addr", bus.mem_addr_o, 32'h100);
    wait_ack(1'b1, 12, cyc);
    check("sim_d_latency", cyc, 32'd2);
    check("sim_d_rdata", bus.d_rdata_o, 32'h11112222);
    bus.d_req_i = 1'b0;
    mem_rdata = 32'h33334444;
    step();
    check("sim_second_addr", bus.mem_addr_o, 32'h20);
    check("sim_second_en", {31'd0, bus.mem_enable_o}, 32'd1);
    wait_ack(1'b0, 12, cyc);
    check("sim_if_data", bus.if_data_o, 32'h33334444);
    check("sim_d_rdata_hold", bus.d_rdata_o, 32'h11112222);
    bus.if_req_i = 1'b0;
    step();
    check("sim_grants", grant_q.size(), 32'd2);
    if (grant_q.size() >= 2) begin
      check("sim_grant0", grant_q[0], 32'h100);
      check("sim_grant1", grant_q[1], 32'h20);
    end

    // Store; requester changes mid-BUSY must not reach the memory port
    lat = 2;
    mem_rdata = 32'h55555555;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h8;
    bus.d_wdata_i = 32'hDEADBEEF;
    step();
    check("st_write", {31'd0, bus.mem_write_o}, 32'd1);
    check("st_wdata", bus.mem_data_o, 32'hDEADBEEF);
    check("st_addr",  bus.mem_addr_o, 32'h8);
    bus.d_addr_i  = 32'h44;
    bus.d_wdata_i = 32'h0;
    step();
    check("st_wdata_hold", bus.mem_data_o, 32'hDEADBEEF);
    check("st_addr_hold",  bus.mem_addr_o, 32'h8);
    wait_ack(1'b1, 12, cyc);
    check("st_latency", cyc, 32'd2);
    check("st_rdata_kept", bus.d_rdata_o, 32'h11112222);
    bus.d_req_i = 1'b0;
    bus.d_we_i  = 1'b0;
    step();
    check("st_ack_single", {31'd0, bus.d_ack_o}, 32'd0);

    // Starvation: data keeps requesting; fetch requests except in d_ack cycles
    lat = 0;
    mem_rdata = 32'hCAFE0001;
    grant_q.delete();
    bus.if_addr_i = 32'h40;
    bus.d_addr_i  = 32'h200;
    bus.if_req_i  = 1'b1;
    bus.d_req_i   = 1'b1;
    for (int i = 0; i < 80 && grant_q.size() < 8; i++) begin
      step();
      bus.if_req_i = ~bus.d_ack_o;
    end
    bus.if_req_i = 1'b0;
    bus.d_req_i  = 1'b0;
    repeat (4) step();
    check("starve_count", {31'd0, grant_q.size() >= 8}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_q.size()) check($sformatf("starve_grant%0d", i), grant_q[i], starve_exp[i]);
    end

    // Zero-wait memory, data port then fetch port, stall every cycle
    for (int p = 1; p >= 0; p--) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step();
        if (p == 1) bus.d_req_i = req_tab[k];
        else bus.if_req_i = req_tab[k];
        #1;
        check($sformatf("zw%0d_en%0d", p, k), {31'd0, bus.mem_enable_o}, {31'd0, en_tab[k]});
        check($sformatf("zw%0d_ack%0d", p, k),
              {31'd0, (p == 1) ? bus.d_ack_o : bus.if_ack_o}, {31'd0, ack_tab[k]});
        check($sformatf("zw%0d_stall%0d", p, k), {31'd0, bus.stall_o}, {31'd0, stall_tab[k]});
      end
      step();
    end

    // Reset one cycle after a data grant, then a stray memory ack
    lat = 5;
    bus.d_req_i  = 1'b1;
    bus.d_we_i   = 1'b0;
    bus.d_addr_i = 32'h400;
    step();
    check("rb_enable_busy", {31'd0, bus.mem_enable_o}, 32'd1);
    rst = 1'b1;
    bus.d_req_i = 1'b0;
    #1;
    check("rb_enable", {31'd0, bus.mem_enable_o}, 32'd0);
    check("rb_d_ack",  {31'd0, bus.d_ack_o}, 32'd0);
    check("rb_addr",   bus.mem_addr_o, 32'd0);
    check("rb_if_data", bus.if_data_o, 32'd0);
    check("rb_d_rdata", bus.d_rdata_o, 32'd0);
    step();
    rst = 1'b0;
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    check("rb_late_d_ack",  {31'd0, bus.d_ack_o}, 32'd0);
    check("rb_late_if_ack", {31'd0, bus.if_ack_o}, 32'd0);
    check("rb_late_rdata",  bus.d_rdata_o, 32'd0);
    step();
    check("rb_idle_enable", {31'd0, bus.mem_enable_o}, 32'd0);
    check("rb_idle_d_ack",  {31'd0, bus.d_ack_o}, 32'd0);

    check("ack_single_cycle", ack_run_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
